bht_predictor: RTL and testbench

BHT_PREDICTOR -- requirements
Module: bht_predictor

---
 rtl/bht_predictor.sv | 128 ++++++++++++
 tb/tb_bht_predictor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_predictor.sv
// ---------------------------------------------------------------------------
// bht_predictor
//    Direct-mapped branch history table with a 2-bit saturating counter and
//    a full target address per entry.
//
//    Lookup is purely combinational off if_pc. An update takes effect on the
//    rising clk edge where upd_en is high. A lookup in the same cycle
//    therefore sees the pre-edge contents, and the new contents from the
//    following cycle onward.
//
// Ports
//    clk           : single clock, all state changes on its rising edge
//    rstn          : asynchronous active-low reset
//    if_pc         : fetch PC being looked up
//    pred_taken    : lookup hit and counter in a taken state
//    pred_next_pc  : predicted target when pred_taken, else if_pc + 4
//    upd_en        : one resolved branch/jump per asserted cycle
//    upd_pc        : PC of the resolved instruction
//    upd_taken     : resolved direction
//    upd_target    : resolved target address
//    upd_mispred   : resolved instruction caused a flush
//    stat_updates  : saturating count of accepted updates
//    stat_mispred  : saturating count of accepted mispredicted updates
// ---------------------------------------------------------------------------
module bht_predictor #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   output logic [31:0] pred_next_pc,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_mispred,
   output logic [15:0] stat_updates,
   output logic [15:0] stat_mispred
);

   localparam int TAG_W = 30 - IDX_W;

   // Entry storage. The whole table clears on reset, so it is kept in flops.
   logic             valid_reg  [ENTRIES];
   logic [TAG_W-1:0] tag_reg    [ENTRIES];
   logic [31:0]      target_reg [ENTRIES];
   logic [1:0]       ctr_reg    [ENTRIES];

   logic [15:0] stat_updates_reg;
   logic [15:0] stat_mispred_reg;

   // PC[1:0] does not take part in indexing or tagging.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

   // ---------------- lookup ----------------
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;

   assign lk_idx = if_pc[IDX_W+1:2];
   assign lk_tag = if_pc[31:IDX_W+2];
   assign lk_hit = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);

   // Reset clears every valid bit, so pred_taken falls to 0 during reset.
   assign pred_taken   = lk_hit && ctr_reg[lk_idx][1];
   assign pred_next_pc = pred_taken ? target_reg[lk_idx] : (if_pc + 32'd4);

   // ---------------- update ----------------
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic [1:0]       ctr_next;

   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = upd_pc[31:IDX_W+2];
   assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

   // Saturating counter step for an update that hits.
   always_comb begin
      ctr_next = ctr_reg[upd_idx];
      if (upd_taken) begin
         if (ctr_reg[upd_idx] != 2'd3) ctr_next = ctr_reg[upd_idx] + 2'd1;
      end else begin
         if (ctr_reg[upd_idx] != 2'd0) ctr_next = ctr_reg[upd_idx] - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_reg[i]  <= 1'b0;
            tag_reg[i]    <= '0;
            target_reg[i] <= '0;
            ctr_reg[i]    <= 2'd1;
         end
      end else if (upd_en) begin
         if (upd_hit) begin
            ctr_reg[upd_idx] <= ctr_next;
            if (upd_taken) target_reg[upd_idx] <= upd_target;
         end else if (upd_taken) begin
            // Only taken branches allocate; a new entry starts weakly taken.
            valid_reg[upd_idx]  <= 1'b1;
            tag_reg[upd_idx]    <= upd_tag;
            target_reg[upd_idx] <= upd_target;
            ctr_reg[upd_idx]    <= 2'd2;
         end
      end
   end

   // ---------------- statistics ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_updates_reg <= '0;
         stat_mispred_reg <= '0;
      end else if (upd_en) begin
         if (stat_updates_reg != 16'hFFFF) stat_updates_reg <= stat_updates_reg + 16'd1;
         if (upd_mispred && (stat_mispred_reg != 16'hFFFF))
            stat_mispred_reg <= stat_mispred_reg + 16'd1;
      end
   end

   assign stat_updates = stat_updates_reg;
   assign stat_mispred = stat_mispred_reg;

endmodule

// File: tb/tb_bht_predictor.sv
// ---------------------------------------------------------------------------
// tb_bht_predictor
//    Stimulus pushes the expected lookup/statistics response into a queue.
//    A monitor on the falling edge pops one entry and compares it. Expected
//    values come from a table model written with plain integers. Directed
//    steps add fixed-value checks for the documented scenarios.
// ---------------------------------------------------------------------------
module tb_bht_predictor;

   localparam int ENTRIES = 16;
   localparam int IDX_W   = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] if_pc = '0;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic        upd_en = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_mispred = 1'b0;
   logic [15:0] stat_updates;
   logic [15:0] stat_mispred;

   bht_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .if_pc        (if_pc),
      .pred_taken   (pred_taken),
      .pred_next_pc (pred_next_pc),
      .upd_en       (upd_en),
      .upd_pc       (upd_pc),
      .upd_taken    (upd_taken),
      .upd_target   (upd_target),
      .upd_mispred  (upd_mispred),
      .stat_updates (stat_updates),
      .stat_mispred (stat_mispred)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pt;
      logic [31:0] npc;
      logic [15:0] su;
      logic [15:0] sm;
      logic [31:0] pc;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;
   bit   verbose  = 1'b1;

   // ---------------- reference model ----------------
   bit          m_valid  [ENTRIES];
   longint      m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   int          m_su;
   int          m_sm;

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i]  = 1'b0;
         m_tag[i]    = 0;
         m_target[i] = '0;
         m_ctr[i]    = 1;
      end
      m_su = 0;
      m_sm = 0;
   endfunction

   function automatic int idx_of(logic [31:0] pc);
      return int'((longint'(pc) / 4) % ENTRIES);
   endfunction

   function automatic longint tag_of(logic [31:0] pc);
      return longint'(pc) / (4 * ENTRIES);
   endfunction

   function automatic exp_t model_lookup(logic [31:0] pc);
      exp_t e;
      int   i;
      bit   hit;
      i     = idx_of(pc);
      hit   = m_valid[i] && (m_tag[i] == tag_of(pc));
      e.pt  = hit && (m_ctr[i] >= 2);
      e.npc = e.pt ? m_target[i] : 32'(longint'(pc) + 4);
      e.su  = 16'(m_su);
      e.sm  = 16'(m_sm);
      e.pc  = pc;
      return e;
   endfunction

   function automatic void model_update(logic [31:0] pc, logic t, logic [31:0] tgt, logic mis);
      int i;
      bit hit;
      if (m_su < 65535) m_su++;
      if (mis && m_sm < 65535) m_sm++;
      i   = idx_of(pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(pc));
      if (hit) begin
         if (t) begin
            m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_target[i] = tgt;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end else if (t) begin
         m_valid[i]  = 1'b1;
         m_tag[i]    = tag_of(pc);
         m_target[i] = tgt;
         m_ctr[i]    = 2;
      end
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en && sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         if (verbose)
            $display("txn if_pc=%h pred_taken=%b pred_next_pc=%h stats=%0d/%0d",
                     if_pc, pred_taken, pred_next_pc, stat_updates, stat_mispred);
         check("mon_if_pc", if_pc, e.pc);
         check("mon_pred_taken", {31'b0, pred_taken}, {31'b0, e.pt});
         check("mon_pred_next_pc", pred_next_pc, e.npc);
         check("mon_stat_updates", {16'b0, stat_updates}, {16'b0, e.su});
         check("mon_stat_mispred", {16'b0, stat_mispred}, {16'b0, e.sm});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic [31:0] pc, input logic ue, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic um);
      @(posedge clk);
      #1;
      if_pc       = pc;
      upd_en      = ue;
      upd_pc      = upc;
      upd_taken   = ut;
      upd_target  = utgt;
      upd_mispred = um;
      sbq.push_back(model_lookup(pc));
      if (ue) model_update(upc, ut, utgt, um);
   endtask

   // Fixed-value check of the lookup presented in the current step.
   task automatic dchk(input string name, input logic ept, input logic [31:0] enpc);
      @(negedge clk);
      #1;
      check({name, "_taken"}, {31'b0, pred_taken}, {31'b0, ept});
      check({name, "_next"}, pred_next_pc, enpc);
   endtask

   task automatic dstat(input string name, input logic [15:0] esu, input logic [15:0] esm);
      check({name, "_upd"}, {16'b0, stat_updates}, {16'b0, esu});
      check({name, "_mis"}, {16'b0, stat_mispred}, {16'b0, esm});
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] tg;
      int          k;
      k  = int'($urandom_range(0, 4));
      tg = (k == 4) ? 32'h03FF_FFFF : 32'(k);
      return (tg << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2)
             | 32'($urandom_range(0, 3));
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0] upc;
      model_reset();
      rstn  = 1'b0;
      if_pc = 32'h10;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hold_taken", {31'b0, pred_taken}, 32'd0);
      check("rst_hold_next", pred_next_pc, 32'h14);
      @(negedge clk);
      rstn   = 1'b1;
      mon_en = 1'b1;

      // Reset state
      step(32'h10, 0, 0, 0, 0, 0);
      dchk("reset_lookup", 1'b0, 32'h14);
      dstat("reset_stats", 16'd0, 16'd0);

      // Allocation of a taken branch
      step(32'h10, 1, 32'h20, 1, 32'h100, 1);
      step(32'h20, 0, 0, 0, 0, 0);
      dchk("alloc", 1'b1, 32'h100);
      dstat("alloc_stats", 16'd1, 16'd1);

      // Counter walk on the same entry (ctr 2 at start)
      step(32'h20, 1, 32'h20, 0, 32'h0, 0);    // ->1
      step(32'h20, 1, 32'h20, 0, 32'h0, 0);    // sees 1, ->0
      dchk("ctr_nt1", 1'b0, 32'h24);
      step(32'h20, 1, 32'h20, 1, 32'h100, 0);  // sees 0, ->1
      step(32'h20, 1, 32'h20, 1, 32'h100, 0);  // sees 1, ->2
      dchk("ctr_t1", 1'b0, 32'h24);
      step(32'h20, 1, 32'h20, 1, 32'h100, 0);  // sees 2, ->3
      dchk("ctr_t2", 1'b1, 32'h100);
      step(32'h20, 1, 32'h20, 1, 32'h100, 0);  // sees 3, stays 3
      step(32'h20, 1, 32'h20, 0, 32'h0, 0);    // sees 3, ->2
      step(32'h20, 1, 32'h20, 0, 32'h0, 0);    // sees 2, ->1
      dchk("ctr_sat3", 1'b1, 32'h100);
      step(32'h20, 0, 0, 0, 0, 0);             // sees 1
      dchk("ctr_back1", 1'b0, 32'h24);

      // Miss with not-taken does not allocate
      step(32'h20, 1, 32'h40, 0, 32'h500, 0);
      step(32'h40, 0, 0, 0, 0, 0);
      dchk("nt_noalloc", 1'b0, 32'h44);

      // Alias replacement at the same index
      step(32'h20, 1, 32'h20, 1, 32'h100, 0);  // 1 -> 2
      step(32'h20, 1, 32'h60, 1, 32'h200, 0);  // sees 0x20 taken, replace
      dchk("alias_pre", 1'b1, 32'h100);
      step(32'h20, 0, 0, 0, 0, 0);
      dchk("alias_old", 1'b0, 32'h24);
      step(32'h60, 0, 0, 0, 0, 0);
      dchk("alias_new", 1'b1, 32'h200);

      // Wrap of the sequential next PC
      step(32'hFFFF_FFFC, 0, 0, 0, 0, 0);
      dchk("pc_wrap", 1'b0, 32'h0000_0000);

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         upc = rand_pc();
         step(($urandom_range(0, 1) != 0) ? upc : rand_pc(),
              ($urandom_range(0, 3) != 0), upc, $urandom_range(0, 1) != 0,
              $urandom, $urandom_range(0, 1) != 0);
      end

      // Counter saturation: long run of mispredicted updates
      verbose = 1'b0;
      for (int n = 0; n < 70000; n++) begin
         upc = rand_pc();
         step(($urandom_range(0, 1) != 0) ? upc : rand_pc(), 1'b1, upc,
              $urandom_range(0, 1) != 0, $urandom, 1'b1);
      end
      verbose = 1'b1;
      step(32'h10, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      dstat("stat_sat", 16'hFFFF, 16'hFFFF);

      // Asynchronous reset between edges after training
      step(32'h60, 1, 32'h60, 1, 32'h200, 0);
      step(32'h60, 1, 32'h60, 1, 32'h200, 0);
      @(posedge clk);
      #1;
      mon_en      = 1'b0;
      sbq.delete();
      if_pc       = 32'h60;
      upd_en      = 1'b1;
      upd_pc      = 32'h60;
      upd_taken   = 1'b1;
      upd_target  = 32'h300;
      upd_mispred = 1'b1;
      #2;
      check("prerst_taken", {31'b0, pred_taken}, 32'd1);
      check("prerst_next", pred_next_pc, 32'h200);
      rstn = 1'b0;
      #1;
      check("async_rst_taken", {31'b0, pred_taken}, 32'd0);
      check("async_rst_next", pred_next_pc, 32'h64);
      dstat("async_rst_stats", 16'd0, 16'd0);
      @(posedge clk);
      #1;
      check("rst_edge_taken", {31'b0, pred_taken}, 32'd0);
      dstat("rst_edge_stats", 16'd0, 16'd0);
      upd_en = 1'b0;
      model_reset();
      #2;
      rstn   = 1'b1;
      mon_en = 1'b1;
      step(32'h60, 0, 0, 0, 0, 0);
      dchk("post_rst", 1'b0, 32'h64);
      step(32'h60, 1, 32'h60, 1, 32'h300, 0);
      step(32'h60, 0, 0, 0, 0, 0);
      dchk("post_rst_alloc", 1'b1, 32'h300);
      dstat("post_rst_stats", 16'd1, 16'd0);

      // Drain
      step(32'h0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      check("sbq_drain", 32'(sbq.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
